// File: rtl/ifetch_queue_if.sv
// Fetch-unit bus: decode handshake, redirect request, ROM read port and debug PC.
interface ifetch_queue_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ROM_AW = 14
);
    logic              stall;
    logic              redirect;
    logic [XLEN-1:0]   redirect_target;
    logic              rom_en;
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic              inst_valid;
    logic [31:0]       inst;
    logic [XLEN-1:0]   inst_pc;
    logic [XLEN-1:0]   fetch_pc;

    modport master (
        input  stall, redirect, redirect_target, rom_data,
        output rom_en, rom_addr, inst_valid, inst, inst_pc, fetch_pc
    );

    modport slave (
        output stall, redirect, redirect_target, rom_data,
        input  rom_en, rom_addr, inst_valid, inst, inst_pc, fetch_pc
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch: PC sequencing, 1-cycle ROM reads, and a credit-controlled
// instruction queue whose head is presented to decode from registers.
module ifetch_queue #(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int unsigned      QDEPTH   = 4,
    parameter int unsigned      ROM_AW   = 14
) (
    input  logic               clk,
    input  logic               rst,
    ifetch_queue_if.master     bus
);
    localparam int unsigned     PW      = $clog2(QDEPTH);
    localparam int unsigned     CW      = PW + 2;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);
    localparam logic [XLEN-1:0] PC_MASK = ~XLEN'(2'b11);

    logic [31:0]      inst_mem_r [QDEPTH];
    logic [XLEN-1:0]  pc_mem_r   [QDEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    occ_r;
    logic [XLEN-1:0]  fpc_r;
    logic [XLEN-1:0]  req_pc_r;
    logic             req_v_r;
    logic             inst_valid_r;
    logic [31:0]      inst_r;
    logic [XLEN-1:0]  inst_pc_r;

    logic             pop_s;
    logic             push_s;
    logic             issue_s;
    logic [CW-1:0]    credit_s;
    logic [CW-1:0]    remain_s;
    logic [CW-1:0]    occ_next_s;
    logic [PW-1:0]    rd_next_s;
    logic             head_v_s;
    logic [31:0]      head_inst_s;
    logic [XLEN-1:0]  head_pc_s;

    // Handshake, credit check and next head selection.
    always_comb begin
        pop_s     = inst_valid_r & ~bus.stall & ~bus.redirect;
        push_s    = req_v_r & ~bus.redirect;
        // The in-flight read already owns a slot, so it counts against the depth.
        credit_s  = occ_r + CW'(req_v_r) - CW'(pop_s);
        issue_s   = ~bus.redirect & (credit_s < CW'(QDEPTH));
        remain_s  = occ_r - CW'(pop_s);
        rd_next_s = rd_ptr_r + PW'(pop_s);

        if (bus.redirect) begin
            occ_next_s = '0;
        end else begin
            occ_next_s = remain_s + CW'(push_s);
        end

        // Head registers keep their last contents whenever the queue drains.
        if (bus.redirect) begin
            head_v_s    = 1'b0;
            head_inst_s = inst_r;
            head_pc_s   = inst_pc_r;
        end else if (remain_s != '0) begin
            head_v_s    = 1'b1;
            head_inst_s = inst_mem_r[rd_next_s];
            head_pc_s   = pc_mem_r[rd_next_s];
        end else if (push_s) begin
            head_v_s    = 1'b1;
            head_inst_s = bus.rom_data;
            head_pc_s   = req_pc_r;
        end else begin
            head_v_s    = 1'b0;
            head_inst_s = inst_r;
            head_pc_s   = inst_pc_r;
        end
    end

    // Fetch PC, in-flight tracking, queue storage and head output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                inst_mem_r[i] <= 32'h0;
                pc_mem_r[i]   <= '0;
            end
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            occ_r        <= '0;
            fpc_r        <= RESET_PC;
            req_pc_r     <= '0;
            req_v_r      <= 1'b0;
            inst_valid_r <= 1'b0;
            inst_r       <= 32'h0;
            inst_pc_r    <= '0;
        end else begin
            occ_r        <= occ_next_s;
            inst_valid_r <= head_v_s;
            inst_r       <= head_inst_s;
            inst_pc_r    <= head_pc_s;
            if (bus.redirect) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
                req_v_r  <= 1'b0;
                fpc_r    <= bus.redirect_target & PC_MASK;
            end else begin
                rd_ptr_r <= rd_next_s;
                if (push_s) begin
                    inst_mem_r[wr_ptr_r] <= bus.rom_data;
                    pc_mem_r[wr_ptr_r]   <= req_pc_r;
                    wr_ptr_r             <= wr_ptr_r + PW'(1'b1);
                end else begin
                    wr_ptr_r <= wr_ptr_r;
                end
                if (issue_s) begin
                    req_v_r  <= 1'b1;
                    req_pc_r <= fpc_r;
                    fpc_r    <= fpc_r + PC_STEP;
                end else begin
                    req_v_r  <= 1'b0;
                end
            end
        end
    end

    assign bus.rom_en     = issue_s;
    assign bus.rom_addr   = fpc_r[ROM_AW+1:2];
    assign bus.inst_valid = inst_valid_r;
    assign bus.inst       = inst_r;
    assign bus.inst_pc    = inst_pc_r;
    assign bus.fetch_pc   = fpc_r;
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench: per-cycle vector table for fetch/stall/redirect/wrap, then an
// asynchronous mid-stream reset on a second instance with RESET_PC=0x200.
module tb_ifetch_queue;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    ifetch_queue_if #(.XLEN(32), .ROM_AW(14)) bus0 ();
    ifetch_queue_if #(.XLEN(32), .ROM_AW(14)) bus1 ();

    ifetch_queue #(.XLEN(32), .RESET_PC(32'h0), .QDEPTH(4), .ROM_AW(14)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    ifetch_queue #(.XLEN(32), .RESET_PC(32'h200), .QDEPTH(4), .ROM_AW(14)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: word at address a holds 0x1000_0000 + a, one-cycle read latency.
    always @(posedge clk) begin
        if (bus0.rom_en) bus0.rom_data <= 32'h1000_0000 + {18'h0, bus0.rom_addr};
        if (bus1.rom_en) bus1.rom_data <= 32'h1000_0000 + {18'h0, bus1.rom_addr};
    end

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] target;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        rom_en;
        logic [31:0] fetch;
    } vec_t;

    localparam int NV = 37;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t,
                                input logic v, input logic [31:0] p, input logic [31:0] i,
                                input logic e, input logic [31:0] f);
        vec_t x;
        x.stall = s; x.redirect = r; x.target = t; x.valid = v;
        x.pc = p; x.inst = i; x.rom_en = e; x.fetch = f;
        return x;
    endfunction

    task automatic check(input string name, input int cyc, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic [31:0] t);
        bus0.stall = s; bus0.redirect = r; bus0.redirect_target = t;
        bus1.stall = s; bus1.redirect = r; bus1.redirect_target = t;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0);

        //            stall redir target        valid pc            inst          en   fetch
        vecs[0]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 32'h0);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 32'h4);
        vecs[2]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        32'h1000_0000, 1'b1, 32'h8);
        vecs[3]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        32'h1000_0001, 1'b1, 32'hC);
        vecs[4]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        32'h1000_0002, 1'b1, 32'h10);
        vecs[5]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        32'h1000_0003, 1'b1, 32'h14);
        vecs[6]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        32'h1000_0003, 1'b1, 32'h18);
        vecs[7]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        32'h1000_0003, 1'b0, 32'h1C);
        vecs[8]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        32'h1000_0003, 1'b0, 32'h1C);
        vecs[9]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        32'h1000_0003, 1'b0, 32'h1C);
        vecs[10] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'hC,        32'h1000_0003, 1'b1, 32'h1C);
        vecs[11] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h10,       32'h1000_0004, 1'b1, 32'h20);
        vecs[12] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h14,       32'h1000_0005, 1'b1, 32'h24);
        vecs[13] = mk(1'b0, 1'b1, 32'h40,       1'b1, 32'h18,       32'h1000_0006, 1'b0, 32'h28);
        vecs[14] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h18,       32'h1000_0006, 1'b1, 32'h40);
        vecs[15] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h18,       32'h1000_0006, 1'b1, 32'h44);
        vecs[16] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h40,       32'h1000_0010, 1'b1, 32'h48);
        vecs[17] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h44,       32'h1000_0011, 1'b1, 32'h4C);
        vecs[18] = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h48,       32'h1000_0012, 1'b1, 32'h50);
        vecs[19] = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h48,       32'h1000_0012, 1'b1, 32'h54);
        vecs[20] = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h48,       32'h1000_0012, 1'b0, 32'h58);
        vecs[21] = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h48,       32'h1000_0012, 1'b0, 32'h58);
        vecs[22] = mk(1'b1, 1'b1, 32'h102,      1'b1, 32'h48,       32'h1000_0012, 1'b0, 32'h58);
        vecs[23] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h48,       32'h1000_0012, 1'b1, 32'h100);
        vecs[24] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h48,       32'h1000_0012, 1'b1, 32'h104);
        vecs[25] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h100,      32'h1000_0040, 1'b1, 32'h108);
        vecs[26] = mk(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'h104,     32'h1000_0041, 1'b0, 32'h10C);
        vecs[27] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h104,      32'h1000_0041, 1'b1, 32'hFFFF_FFF8);
        vecs[28] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h104,      32'h1000_0041, 1'b1, 32'hFFFF_FFFC);
        vecs[29] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFF8, 32'h1000_3FFE, 1'b1, 32'h0);
        vecs[30] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 32'h1000_3FFF, 1'b1, 32'h4);
        vecs[31] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        32'h1000_0000, 1'b1, 32'h8);
        vecs[32] = mk(1'b0, 1'b1, 32'h80,       1'b1, 32'h4,        32'h1000_0001, 1'b0, 32'hC);
        vecs[33] = mk(1'b0, 1'b1, 32'h300,      1'b0, 32'h4,        32'h1000_0001, 1'b0, 32'h80);
        vecs[34] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h4,        32'h1000_0001, 1'b1, 32'h300);
        vecs[35] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h4,        32'h1000_0001, 1'b1, 32'h304);
        vecs[36] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h300,      32'h1000_00C0, 1'b1, 32'h308);

        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < NV; c++) begin
            drive(vecs[c].stall, vecs[c].redirect, vecs[c].target);
            #1;
            check("inst_valid", c, {31'h0, bus0.inst_valid}, {31'h0, vecs[c].valid});
            check("inst_pc",    c, bus0.inst_pc,  vecs[c].pc);
            check("inst",       c, bus0.inst,     vecs[c].inst);
            check("rom_en",     c, {31'h0, bus0.rom_en}, {31'h0, vecs[c].rom_en});
            check("fetch_pc",   c, bus0.fetch_pc, vecs[c].fetch);
            check("rom_addr",   c, {18'h0, bus0.rom_addr}, {18'h0, vecs[c].fetch[15:2]});
            @(negedge clk);
        end

        // Asynchronous reset between edges, while dut0 is streaming.
        drive(1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #2;
        check("pre_reset_valid", 100, {31'h0, bus0.inst_valid}, 32'h1);
        rst = 1'b0;
        #1;
        check("areset_valid0", 101, {31'h0, bus0.inst_valid}, 32'h0);
        check("areset_pc0",    101, bus0.inst_pc,  32'h0);
        check("areset_inst0",  101, bus0.inst,     32'h0);
        check("areset_fetch0", 101, bus0.fetch_pc, 32'h0);
        check("areset_valid1", 101, {31'h0, bus1.inst_valid}, 32'h0);
        check("areset_fetch1", 101, bus1.fetch_pc, 32'h200);
        check("areset_addr1",  101, {18'h0, bus1.rom_addr}, 32'h80);

        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rpc_c0_valid", 102, {31'h0, bus1.inst_valid}, 32'h0);
        check("rpc_c0_en",    102, {31'h0, bus1.rom_en}, 32'h1);
        check("rpc_c0_fetch", 102, bus1.fetch_pc, 32'h200);
        @(negedge clk);
        #1;
        check("rpc_c1_valid", 103, {31'h0, bus1.inst_valid}, 32'h0);
        check("rpc_c1_fetch", 103, bus1.fetch_pc, 32'h204);
        @(negedge clk);
        #1;
        check("rpc_c2_valid", 104, {31'h0, bus1.inst_valid}, 32'h1);
        check("rpc_c2_pc",    104, bus1.inst_pc, 32'h200);
        check("rpc_c2_inst",  104, bus1.inst,    32'h1000_0080);
        @(negedge clk);
        #1;
        check("rpc_c3_pc",    105, bus1.inst_pc, 32'h204);
        check("rpc_c3_inst",  105, bus1.inst,    32'h1000_0081);
        check("rpc_c3_fetch", 105, bus1.fetch_pc, 32'h20C);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
